julia_iter_ctrl: RTL

Per-pixel iteration controller and initiator side of the Julia single-step calculator handshake. Takes one start point (x0, y0) per pixel plus the constant c. Repeatedly issues z = z^2 + c steps to the calculator, feeding each result back as the next operand. Stops on escape or at MAX_ITER and emits the iteration count to the colour/pixel writer downstream.

---
 rtl/julia_iter_ctrl_if.sv | 44 ++++
 rtl/julia_iter_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/julia_iter_ctrl_if.sv
// Handshake bundle for the Julia iteration controller:
// pixel request, calculator step and result channels.
interface julia_iter_ctrl_if #(
  parameter int ITER_W = 8
);
  logic                 pix_valid;
  logic                 pix_ready;
  logic signed [31:0]   pix_x0;
  logic signed [31:0]   pix_y0;
  logic signed [31:0]   cr;
  logic signed [31:0]   ci;
  logic                 calc_en;
  logic signed [31:0]   calc_x;
  logic signed [31:0]   calc_y;
  logic signed [31:0]   calc_cr;
  logic signed [31:0]   calc_ci;
  logic                 calc_done;
  logic signed [31:0]   calc_xn;
  logic signed [31:0]   calc_yn;
  logic signed [31:0]   calc_mag;
  logic                 res_valid;
  logic                 res_ready;
  logic [ITER_W-1:0]    res_iter;
  logic                 res_escaped;
  logic                 res_err;

  modport master (
    input  pix_valid, pix_x0, pix_y0, cr, ci,
    input  calc_done, calc_xn, calc_yn, calc_mag,
    input  res_ready,
    output pix_ready, calc_en, calc_x, calc_y,
    output calc_cr, calc_ci,
    output res_valid, res_iter, res_escaped, res_err
  );

  modport slave (
    output pix_valid, pix_x0, pix_y0, cr, ci,
    output calc_done, calc_xn, calc_yn, calc_mag,
    output res_ready,
    input  pix_ready, calc_en, calc_x, calc_y,
    input  calc_cr, calc_ci,
    input  res_valid, res_iter, res_escaped, res_err
  );
endinterface

// File: rtl/julia_iter_ctrl.sv
// Per-pixel Julia iteration controller: issues z=z^2+c steps to
// the single-step calculator until escape or MAX_ITER.
// Ports: clk, rst (sync, active-high), bus (julia_iter_ctrl_if.master):
//   pix_* request in, calc_* step handshake, res_* result out.
// Optional macro JL_CALC_TIMEOUT_EN: WAIT watchdog, sets res_err.
`ifndef JL_MUL
`define JL_MUL 1000
`endif

module julia_iter_ctrl #(
  parameter int        MAX_ITER  = 255,
  parameter int        ITER_W    = 8,
  parameter int signed ESC_LIMIT = 4 * `JL_MUL * `JL_MUL,
  parameter int        TIMEOUT   = 1023
) (
  input  logic               clk,
  input  logic               rst,
  julia_iter_ctrl_if.master  bus
);

  localparam logic [ITER_W-1:0] MAX_I = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_OUT
  } state_t;

  state_t             state;
  logic               pix_ready_q;
  logic               calc_en_q;
  logic signed [31:0] x_q, y_q, cr_q, ci_q;
  logic signed [31:0] xn_q, yn_q, mag_q;
  logic [ITER_W-1:0]  iter_q;
  logic               res_valid_q;
  logic [ITER_W-1:0]  res_iter_q;
  logic               esc_q;
  logic               err_q;
  logic               escape;

  // Negative magnitude means the squares overflowed: escaped.
  assign escape = mag_q[31] || (mag_q > ESC_LIMIT);

`ifdef JL_CALC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] wcnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pix_ready_q <= 1'b1;
      calc_en_q   <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      cr_q        <= '0;
      ci_q        <= '0;
      xn_q        <= '0;
      yn_q        <= '0;
      mag_q       <= '0;
      iter_q      <= '0;
      res_valid_q <= 1'b0;
      res_iter_q  <= '0;
      esc_q       <= 1'b0;
      err_q       <= 1'b0;
`ifdef JL_CALC_TIMEOUT_EN
      wcnt        <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.pix_valid) begin
            x_q         <= bus.pix_x0;
            y_q         <= bus.pix_y0;
            cr_q        <= bus.cr;
            ci_q        <= bus.ci;
            iter_q      <= '0;
            err_q       <= 1'b0;
            pix_ready_q <= 1'b0;
            calc_en_q   <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef JL_CALC_TIMEOUT_EN
          wcnt  <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.calc_done) begin
            xn_q      <= bus.calc_xn;
            yn_q      <= bus.calc_yn;
            mag_q     <= bus.calc_mag;
            iter_q    <= (iter_q == MAX_I) ? iter_q
                                           : iter_q + 1'b1;
            calc_en_q <= 1'b0;
            state     <= S_EVAL;
          end
`ifdef JL_CALC_TIMEOUT_EN
          else if (wcnt == TO_LAST) begin
            calc_en_q   <= 1'b0;
            err_q       <= 1'b1;
            esc_q       <= 1'b0;
            res_iter_q  <= iter_q;
            res_valid_q <= 1'b1;
            state       <= S_OUT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end
        S_EVAL: begin
          if (escape) begin
            esc_q       <= 1'b1;
            res_iter_q  <= iter_q;
            res_valid_q <= 1'b1;
            state       <= S_OUT;
          end else if (iter_q == MAX_I) begin
            esc_q       <= 1'b0;
            res_iter_q  <= iter_q;
            res_valid_q <= 1'b1;
            state       <= S_OUT;
          end else begin
            x_q       <= xn_q;
            y_q       <= yn_q;
            calc_en_q <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_OUT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            pix_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pix_ready   = pix_ready_q;
  assign bus.calc_en     = calc_en_q;
  assign bus.calc_x      = x_q;
  assign bus.calc_y      = y_q;
  assign bus.calc_cr     = cr_q;
  assign bus.calc_ci     = ci_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_iter    = res_iter_q;
  assign bus.res_escaped = esc_q;
  assign bus.res_err     = err_q;

endmodule
